// File: rtl/weight_pkg.sv
// Shared types and default sizing for the weight memory write path.
package weight_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } loader_state_t;

    localparam int DATA_BITS    = 16;
    localparam int NUM_WEIGHTS  = 784;
    localparam int ADDRESS_BITS = 10;

endpackage

// File: rtl/weight_loader.sv
// Streams one neuron's weights into its weight memory with an auto-incrementing address,
// then reports done, or error on a bad neuron select or a stream of the wrong length.
module weight_loader
    import weight_pkg::*;
#(
    parameter int data_bits    = DATA_BITS,
    parameter int num_weights  = NUM_WEIGHTS,
    parameter int address_bits = ADDRESS_BITS,
    parameter int num_neurons  = 30,
    parameter int neuron_bits  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [neuron_bits-1:0]  neuron_id,
    input  logic                    abort,
    input  logic                    s_valid,
    input  logic [data_bits-1:0]    s_data,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic                    write_en,
    output logic [address_bits-1:0] write_add,
    output logic [data_bits-1:0]    weight_in,
    output logic [neuron_bits-1:0]  wr_neuron,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    if (num_weights > 2**address_bits) begin : g_bad_address_bits
        $error("weight_loader: num_weights does not fit in address_bits");
    end
    if (num_neurons > 2**neuron_bits) begin : g_bad_neuron_bits
        $error("weight_loader: num_neurons does not fit in neuron_bits");
    end

    localparam logic [address_bits-1:0] LAST_ADDR    = address_bits'(num_weights - 1);
    localparam logic [neuron_bits:0]    NEURON_LIMIT = (neuron_bits + 1)'(num_neurons);

    loader_state_t             state;
    logic [address_bits-1:0]   beat_cnt;
    logic                      neuron_ok;

    assign neuron_ok = ({1'b0, neuron_id} < NEURON_LIMIT);

    // abort gates ready so a beat offered on the abort edge is never taken
    assign s_ready = (state == LOAD) && !abort;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            write_en  <= 1'b0;
            write_add <= '0;
            weight_in <= '0;
            wr_neuron <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            write_en <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            if (neuron_ok) begin
                                wr_neuron <= neuron_id;
                                beat_cnt  <= '0;
                                state     <= LOAD;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (s_valid) begin
                            write_en  <= 1'b1;
                            write_add <= beat_cnt;
                            weight_in <= s_data;
                            // A mismatched length still commits the current word before erroring out
                            if (beat_cnt == LAST_ADDR) begin
                                if (s_last) begin
                                    state <= FLUSH;
                                end else begin
                                    error <= 1'b1;
                                    state <= IDLE;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                                if (s_last) begin
                                    error <= 1'b1;
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    FLUSH: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a per-cycle reference model and literal spot checks.
module tb_weight_loader;

    localparam int DW = 16;
    localparam int NW = 4;
    localparam int AW = 2;
    localparam int NN = 3;
    localparam int NB = 2;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic [NB-1:0] neuron_id = '0;
    logic          abort     = 1'b0;
    logic          s_valid   = 1'b0;
    logic [DW-1:0] s_data    = '0;
    logic          s_last    = 1'b0;
    logic          s_ready;
    logic          write_en;
    logic [AW-1:0] write_add;
    logic [DW-1:0] weight_in;
    logic [NB-1:0] wr_neuron;
    logic          busy;
    logic          done;
    logic          error;

    weight_loader #(
        .data_bits(DW), .num_weights(NW), .address_bits(AW),
        .num_neurons(NN), .neuron_bits(NB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .neuron_id(neuron_id),
        .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .write_en(write_en), .write_add(write_add),
        .weight_in(weight_in), .wr_neuron(wr_neuron), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: phase 0 = waiting for start, 1 = taking beats, 2 = last word landing
    int            m_phase = 0;
    int            m_cnt   = 0;
    logic          m_we    = 1'b0;
    logic [AW-1:0] m_add   = '0;
    logic [DW-1:0] m_data  = '0;
    logic [NB-1:0] m_nrn   = '0;
    logic          m_done  = 1'b0;
    logic          m_err   = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_cnt = 0; m_we = 1'b0; m_add = '0; m_data = '0;
            m_nrn = '0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
            if (abort && m_phase != 0) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (start && !abort) begin
                    if (int'(neuron_id) < NN) begin
                        m_nrn = neuron_id; m_cnt = 0; m_phase = 1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (m_phase == 1) begin
                if (s_valid) begin
                    m_we = 1'b1; m_add = AW'(m_cnt); m_data = s_data;
                    m_cnt++;
                    if (s_last && m_cnt == NW) m_phase = 2;
                    else if (s_last || m_cnt == NW) begin
                        m_err = 1'b1; m_phase = 0;
                    end
                end
            end else begin
                m_done = 1'b1; m_phase = 0;
            end
        end
    end

    // Per-cycle comparison plus a log of writes and pulses for the directed checks
    logic [AW-1:0] wq_add[$];
    logic [DW-1:0] wq_data[$];
    int n_done = 0, n_err = 0, cyc = 0, last_wr_cyc = -1, done_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        check("write_en", 32'(write_en), 32'(m_we));
        check("write_add", 32'(write_add), 32'(m_add));
        check("weight_in", 32'(weight_in), 32'(m_data));
        check("wr_neuron", 32'(wr_neuron), 32'(m_nrn));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("s_ready", 32'(s_ready), 32'((m_phase == 1) && !abort));
        check("done", 32'(done), 32'(m_done));
        check("error", 32'(error), 32'(m_err));
        if (done && error) check("done_and_error", 32'(1), 32'(0));
        if (write_en) begin
            wq_add.push_back(write_add);
            wq_data.push_back(weight_in);
            last_wr_cyc = cyc;
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (error) n_err++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        wq_add.delete(); wq_data.delete();
        n_done = 0; n_err = 0; last_wr_cyc = -1; done_cyc = -1;
    endtask

    task automatic do_start(input logic [NB-1:0] id);
        start = 1'b1; neuron_id = id;
        step();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        s_valid = 1'b1; s_data = d; s_last = last;
        step();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic [DW-1:0] d3);
        logic [DW-1:0] exp_d[4];
        exp_d = '{d0, d1, d2, d3};
        check({tag, "_nwrites"}, 32'(wq_add.size()), 32'(n));
        for (int i = 0; i < n && i < wq_add.size(); i++) begin
            check({tag, "_addr"}, 32'(wq_add[i]), 32'(i));
            check({tag, "_data"}, 32'(wq_data[i]), 32'(exp_d[i]));
        end
    endtask

    initial begin
        step(); step();
        check("rst_write_en", 32'(write_en), 0);
        check("rst_write_add", 32'(write_add), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        reset_n = 1'b1;
        step();

        // 1: back-to-back load into neuron 2
        clear_log();
        do_start(2'd2);
        send_beat(16'h000A, 1'b0);
        send_beat(16'h000B, 1'b0);
        send_beat(16'h000C, 1'b0);
        send_beat(16'h000D, 1'b1);
        repeat (3) step();
        check_writes("t1", 4, 16'h000A, 16'h000B, 16'h000C, 16'h000D);
        check("t1_done_count", 32'(n_done), 1);
        check("t1_err_count", 32'(n_err), 0);
        check("t1_done_latency", 32'(done_cyc - last_wr_cyc), 1);
        check("t1_wr_neuron", 32'(wr_neuron), 2);

        // 2: same load with a bubble after every beat
        clear_log();
        do_start(2'd2);
        for (int i = 0; i < 8; i++) begin
            s_valid = (i % 2 == 0);
            s_data  = DW'(16'h000A + i / 2);
            s_last  = (i == 6);
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) step();
        check_writes("t2", 4, 16'h000A, 16'h000B, 16'h000C, 16'h000D);
        check("t2_done_count", 32'(n_done), 1);

        // 3: stream ends early
        clear_log();
        do_start(2'd0);
        send_beat(16'h0011, 1'b0);
        send_beat(16'h0022, 1'b1);
        check("t3_err_pulse", 32'(error), 1);
        check("t3_busy", 32'(busy), 0);
        repeat (3) step();
        check_writes("t3", 2, 16'h0011, 16'h0022, 16'h0, 16'h0);
        check("t3_done_count", 32'(n_done), 0);
        check("t3_err_count", 32'(n_err), 1);

        // 4: stream missing its last marker, then an out-of-range neuron
        clear_log();
        do_start(2'd1);
        for (int i = 0; i < 4; i++) send_beat(DW'(16'h0100 + i), 1'b0);
        repeat (3) step();
        check_writes("t4", 4, 16'h0100, 16'h0101, 16'h0102, 16'h0103);
        check("t4_done_count", 32'(n_done), 0);
        check("t4_err_count", 32'(n_err), 1);
        clear_log();
        do_start(2'd3);
        check("t4_badid_err", 32'(error), 1);
        check("t4_badid_busy", 32'(busy), 0);
        repeat (3) step();
        check("t4_badid_nwrites", 32'(wq_add.size()), 0);

        // 5a: abort mid-load with a beat offered on the abort edge
        clear_log();
        do_start(2'd1);
        send_beat(16'h0031, 1'b0);
        send_beat(16'h0032, 1'b0);
        abort = 1'b1; s_valid = 1'b1; s_data = 16'h0099;
        #1;
        check("t5_ready_on_abort", 32'(s_ready), 0);
        step();
        abort = 1'b0; s_valid = 1'b0;
        check("t5_busy_after_abort", 32'(busy), 0);
        repeat (3) step();
        check_writes("t5a", 2, 16'h0031, 16'h0032, 16'h0, 16'h0);
        check("t5a_done_count", 32'(n_done), 0);
        check("t5a_err_count", 32'(n_err), 0);

        // 5b: start with abort in idle does nothing
        start = 1'b1; abort = 1'b1; neuron_id = 2'd0;
        step();
        start = 1'b0; abort = 1'b0;
        check("t5_start_abort_busy", 32'(busy), 0);

        // 5c: asynchronous reset mid-load, then a fresh load
        do_start(2'd2);
        send_beat(16'h0041, 1'b0);
        send_beat(16'h0042, 1'b0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_write_en", 32'(write_en), 0);
        check("t5_rst_write_add", 32'(write_add), 0);
        check("t5_rst_weight_in", 32'(weight_in), 0);
        check("t5_rst_wr_neuron", 32'(wr_neuron), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_error", 32'(error), 0);
        step();
        reset_n = 1'b1;
        step();
        clear_log();
        do_start(2'd1);
        send_beat(16'h0005, 1'b0);
        send_beat(16'h0006, 1'b0);
        send_beat(16'h0007, 1'b0);
        send_beat(16'h0008, 1'b1);
        repeat (3) step();
        check_writes("t5c", 4, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
        check("t5c_done_count", 32'(n_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
